// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt/trap controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam int unsigned SRC_TRAP  = 0;
    localparam int unsigned SRC_INTR  = 1;
    localparam int unsigned SRC_UART  = 2;
    localparam int unsigned SRC_TIMER = 3;

    localparam int unsigned NSRC_DEF       = 4;
    localparam logic [15:0] VEC_BASE_DEF   = 16'h0020;
    localparam logic [15:0] VEC_STRIDE_DEF = 16'h0002;
    localparam int unsigned STAT_IE_BIT    = 7;

    // Handler address of a source; wraps modulo 2^16.
    function automatic logic [15:0] vec_of(input logic [15:0] base,
                                           input logic [15:0] stride,
                                           input int unsigned idx);
        return base + 16'(idx) * stride;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, reported as {valid, index}.
module irq_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/trap controller: edge capture, mask/enable, priority pick, req/ack/ret handshake.
// Optional preemption of a running handler by higher-priority sources: define IRQ_NESTING_EN.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NSRC       = NSRC_DEF,
    parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_in,
    output logic            irq_req,
    input  logic            irq_ack,
    output logic [15:0]     irq_vec,
    input  logic            irq_ret,
    input  logic            bus_we,
    input  logic [1:0]      bus_addr,
    input  logic [15:0]     bus_wdata,
    output logic [15:0]     bus_rdata
);

    localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    state_t          state_q, state_d;
    logic [NSRC-1:0] src_prev, pend, pend_d, mask;
    logic [NSRC-1:0] edges, elig, cand, ack_clr, w1c_clr;
    logic            ie, prev_ie;
    logic [IW-1:0]   active_id, win_idx;
    logic            win_valid;
    logic            take_ack, take_ret, load_vec;
    logic            wr_mask, wr_pend, wr_stat;
    logic            unused_wdata;

    assign unused_wdata = ^bus_wdata;

    assign wr_mask = bus_we && (bus_addr == ADDR_MASK);
    assign wr_pend = bus_we && (bus_addr == ADDR_PEND);
    assign wr_stat = bus_we && (bus_addr == ADDR_STAT);

    assign edges = src_in & ~src_prev;
    // Trap (bit 0) bypasses both mask and global enable.
    assign elig  = (pend & (mask | NSRC'(1)) & {NSRC{ie}}) | (pend & NSRC'(1));

`ifdef IRQ_NESTING_EN
    localparam int unsigned SPW = $clog2(NSRC + 1);

    logic            nest_q;
    logic [SPW-1:0]  sp;
    logic [IW-1:0]   stk_id [NSRC];
    logic            stk_ie [NSRC];
    logic [NSRC-1:0] above;

    always_comb begin
        above = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            above[i] = (i < int'(active_id));
        end
    end

    // While a handler runs, only strictly higher-priority sources compete, ignoring ie.
    assign cand = (state_q == SERVICE || nest_q) ? (pend & (mask | NSRC'(1)) & above) : elig;
`else
    assign cand = elig;
`endif

    irq_prio_enc #(.N(NSRC), .IW(IW)) u_prio (
        .req   (cand),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Next-state and handshake strobes.
    always_comb begin
        state_d  = state_q;
        take_ack = 1'b0;
        take_ret = 1'b0;
        load_vec = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = REQ;
                    load_vec = 1'b1;
                end
            end
            REQ: begin
                if (irq_ack && win_valid) begin
                    state_d  = SERVICE;
                    take_ack = 1'b1;
                end else if (!win_valid) begin
`ifdef IRQ_NESTING_EN
                    state_d = nest_q ? SERVICE : IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    load_vec = 1'b1;
                end
            end
            SERVICE: begin
                if (irq_ret) begin
                    take_ret = 1'b1;
`ifdef IRQ_NESTING_EN
                    state_d  = (sp != '0) ? SERVICE : IDLE;
                end else if (win_valid) begin
                    state_d  = REQ;
                    load_vec = 1'b1;
`else
                    state_d  = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack_clr = take_ack ? (NSRC'(1) << win_idx) : '0;
    assign w1c_clr = wr_pend ? bus_wdata[NSRC-1:0] : '0;
    // A new edge wins over any clear in the same cycle.
    assign pend_d  = (pend & ~w1c_clr & ~ack_clr) | edges;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            src_prev  <= '0;
            pend      <= '0;
            mask      <= '0;
            ie        <= 1'b0;
            prev_ie   <= 1'b0;
            active_id <= '0;
            irq_req   <= 1'b0;
            irq_vec   <= VEC_BASE;
        end else begin
            state_q  <= state_d;
            src_prev <= src_in;
            pend     <= pend_d;
            irq_req  <= (state_d == REQ);
            if (wr_mask) mask <= bus_wdata[NSRC-1:0];
            if (wr_stat) ie <= bus_wdata[STAT_IE_BIT];
            if (load_vec) irq_vec <= vec_of(VEC_BASE, VEC_STRIDE, int'(win_idx));
            if (take_ack) begin
                active_id <= win_idx;
                prev_ie   <= ie;
                ie        <= 1'b0;
            end
            if (take_ret) begin
                ie <= prev_ie;
`ifdef IRQ_NESTING_EN
                if (sp != '0) begin
                    active_id <= stk_id[IW'(sp - SPW'(1))];
                    prev_ie   <= stk_ie[IW'(sp - SPW'(1))];
                end
`endif
            end
        end
    end

`ifdef IRQ_NESTING_EN
    // Context stack of preempted handlers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nest_q <= 1'b0;
            sp     <= '0;
            for (int i = 0; i < int'(NSRC); i++) begin
                stk_id[i] <= '0;
                stk_ie[i] <= 1'b0;
            end
        end else begin
            if (state_q == SERVICE && state_d == REQ) begin
                nest_q <= 1'b1;
            end else if (state_d != REQ) begin
                nest_q <= 1'b0;
            end
            if (take_ack && nest_q) begin
                stk_id[IW'(sp)] <= active_id;
                stk_ie[IW'(sp)] <= prev_ie;
                sp              <= sp + SPW'(1);
            end else if (take_ret && sp != '0) begin
                sp <= sp - SPW'(1);
            end
        end
    end
`endif

    // Register read mux.
    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            ADDR_MASK: bus_rdata = 16'(mask);
            ADDR_PEND: bus_rdata = 16'(pend);
            ADDR_STAT: bus_rdata = {8'h00, ie, prev_ie, 2'b00, state_q, 2'(active_id)};
            default:   bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl; expectations follow IRQ_NESTING_EN when defined.
module tb_irq_ctrl;
    import irq_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  src_in;
    logic        irq_req;
    logic        irq_ack;
    logic [15:0] irq_vec;
    logic        irq_ret;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    irq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .src_in    (src_in),
        .irq_req   (irq_req),
        .irq_ack   (irq_ack),
        .irq_vec   (irq_vec),
        .irq_ret   (irq_ret),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; src_in = '0; irq_ack = 1'b0; irq_ret = 1'b0;
        bus_we = 1'b0; bus_addr = ADDR_MASK; bus_wdata = '0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        step();
        bus_we = 1'b0; bus_wdata = '0;
    endtask

    task automatic pulse_src(input logic [3:0] bits);
        src_in = bits;
        step();
        src_in = '0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; step(); irq_ack = 1'b0;
    endtask

    task automatic pulse_ret();
        irq_ret = 1'b1; step(); irq_ret = 1'b0;
    endtask

    task automatic setup(input logic [15:0] m, input logic [15:0] st);
        do_reset();
        bus_write(ADDR_MASK, m);
        bus_write(ADDR_STAT, st);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", irq_req); end
        total++; if (irq_vec !== 16'h0020) begin bad++; $display("FAIL rst_vec got=%h want=0020", irq_vec); end
        bus_addr = ADDR_STAT; #1;
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL rst_stat got=%h want=0000", bus_rdata); end
        bus_addr = ADDR_MASK; #1;
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL rst_mask got=%h want=0000", bus_rdata); end
        bus_addr = ADDR_RSVD; #1;
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL rst_rsvd got=%h want=0000", bus_rdata); end
    endtask

    task automatic test_basic();
        setup(16'h000F, 16'h0080);
        pulse_src(4'b0010);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL t1_req_n1 got=%b want=0", irq_req); end
        step();
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL t1_req_n2 got=%b want=1", irq_req); end
        total++; if (irq_vec !== 16'h0022) begin bad++; $display("FAIL t1_vec got=%h want=0022", irq_vec); end
        pulse_ack();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL t1_req_ack got=%b want=0", irq_req); end
        bus_addr = ADDR_STAT; #1;
        total++; if (bus_rdata !== 16'h0049) begin bad++; $display("FAIL t1_stat_svc got=%h want=0049", bus_rdata); end
        pulse_ret();
        #1;
        total++; if (bus_rdata !== 16'h00C1) begin bad++; $display("FAIL t1_stat_ret got=%h want=00c1", bus_rdata); end
    endtask

    task automatic test_same_cycle();
        setup(16'h000F, 16'h0080);
        pulse_src(4'b0110);
        step();
        total++; if (irq_vec !== 16'h0022 || irq_req !== 1'b1) begin bad++; $display("FAIL t2_first got=%b/%h want=1/0022", irq_req, irq_vec); end
        pulse_ack();
        pulse_ret();
        step();
        total++; if (irq_vec !== 16'h0024 || irq_req !== 1'b1) begin bad++; $display("FAIL t2_second got=%b/%h want=1/0024", irq_req, irq_vec); end
    endtask

    task automatic test_trap();
        do_reset();
        pulse_src(4'b0001);
        step();
        total++; if (irq_vec !== 16'h0020 || irq_req !== 1'b1) begin bad++; $display("FAIL t3_trap got=%b/%h want=1/0020", irq_req, irq_vec); end
        pulse_ack();
        pulse_ret();
        bus_addr = ADDR_STAT; #1;
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL t3_stat got=%h want=0000", bus_rdata); end
    endtask

    task automatic test_w1c_race();
        do_reset();
        pulse_src(4'b1000);
        step();
        src_in = 4'b1000;
        bus_write(ADDR_PEND, 16'h0008);
        src_in = '0;
        bus_addr = ADDR_PEND; #1;
        total++; if (bus_rdata !== 16'h0008) begin bad++; $display("FAIL t4_race got=%h want=0008", bus_rdata); end
        bus_write(ADDR_PEND, 16'h0008);
        bus_addr = ADDR_PEND; #1;
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL t4_w1c got=%h want=0000", bus_rdata); end
        // Level held high must not re-set pend after a clear.
        src_in = 4'b1000;
        step(); step();
        bus_write(ADDR_PEND, 16'h0008);
        step();
        src_in = '0;
        bus_addr = ADDR_PEND; #1;
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL t4_level got=%h want=0000", bus_rdata); end
    endtask

    task automatic test_mask_in_req();
        setup(16'h000F, 16'h0080);
        pulse_src(4'b0010);
        step();
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL t5_req got=%b want=1", irq_req); end
        bus_write(ADDR_MASK, 16'h0000);
        step();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL t5_drop got=%b want=0", irq_req); end
        bus_addr = ADDR_PEND; #1;
        total++; if (bus_rdata !== 16'h0002) begin bad++; $display("FAIL t5_pend got=%h want=0002", bus_rdata); end
        bus_addr = ADDR_STAT; #1;
        total++; if (bus_rdata !== 16'h0080) begin bad++; $display("FAIL t5_idle got=%h want=0080", bus_rdata); end
        pulse_ack();
        pulse_ret();
        #1;
        total++; if (bus_rdata !== 16'h0080 || irq_req !== 1'b0) begin bad++; $display("FAIL t5_stray got=%h/%b want=0080/0", bus_rdata, irq_req); end
    endtask

    task automatic test_nesting();
        setup(16'h000F, 16'h0080);
        pulse_src(4'b0100);
        step();
        total++; if (irq_vec !== 16'h0024) begin bad++; $display("FAIL t6_uart_vec got=%h want=0024", irq_vec); end
        pulse_ack();
        bus_addr = ADDR_STAT; #1;
        total++; if (bus_rdata !== 16'h004A) begin bad++; $display("FAIL t6_svc got=%h want=004a", bus_rdata); end
        pulse_src(4'b0001);
        step();
`ifdef IRQ_NESTING_EN
        total++; if (irq_req !== 1'b1 || irq_vec !== 16'h0020) begin bad++; $display("FAIL t6_preempt got=%b/%h want=1/0020", irq_req, irq_vec); end
        pulse_ack();
        pulse_ret();
        #1;
        total++; if (bus_rdata !== 16'h004A) begin bad++; $display("FAIL t6_pop got=%h want=004a", bus_rdata); end
        pulse_ret();
        #1;
        total++; if (bus_rdata !== 16'h00C2) begin bad++; $display("FAIL t6_out got=%h want=00c2", bus_rdata); end
`else
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL t6_nopreempt got=%b want=0", irq_req); end
        pulse_ret();
        #1;
        total++; if (bus_rdata !== 16'h00C2) begin bad++; $display("FAIL t6_ret got=%h want=00c2", bus_rdata); end
        step();
        total++; if (irq_req !== 1'b1 || irq_vec !== 16'h0020) begin bad++; $display("FAIL t6_trap_late got=%b/%h want=1/0020", irq_req, irq_vec); end
`endif
    endtask

    task automatic test_reset_mid();
        setup(16'h000F, 16'h0080);
        pulse_src(4'b1000);
        step();
        total++; if (irq_vec !== 16'h0026 || irq_req !== 1'b1) begin bad++; $display("FAIL t7_req got=%b/%h want=1/0026", irq_req, irq_vec); end
        #2 reset = 1'b0;
        #1;
        total++; if (irq_req !== 1'b0 || irq_vec !== 16'h0020) begin bad++; $display("FAIL t7_cancel got=%b/%h want=0/0020", irq_req, irq_vec); end
        bus_addr = ADDR_PEND; #1;
        total++; if (bus_rdata !== 16'h0000) begin bad++; $display("FAIL t7_pend got=%h want=0000", bus_rdata); end
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_trap();
        test_w1c_race();
        test_mask_in_req();
        test_nesting();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
